controlador_banco: RTL and testbench
====================================

// Module: controlador_banco
// PURPOSE
//  Initiator-side controller for the 4x8 register-file port (write/dr/wrData, sr1/sr2 -> rdData1/rdData2).
//  Accepts write, read-pair and clear commands over a valid/ready handshake and sequences the register-file port.
//  Returns read results over a valid/ready response channel.
//  Sits between the control unit / debug host and the register file.
// PARAMETERS
//  DATA_W  8  register width; must match register-file wrData/rdData width
//  ADDR_W  2  register index width
//  NREGS   4  registers cleared by CLEAR (indices 0..NREGS-1); NREGS <= 2**ADDR_W
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-low reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       controller can accept a command
//  cmd_op       in   2       00 WRITE, 01 READ, 10 CLEAR, 11 illegal
//  cmd_a        in   ADDR_W  WRITE: dest index; READ: index A
//  cmd_b        in   ADDR_W  READ: index B (ignored otherwise)
//  cmd_data     in   DATA_W  WRITE data
//  rsp_valid    out  1       read result available
//  rsp_ready    in   1       consumer takes result
//  rsp_data_a   out  DATA_W  value of register cmd_a
//  rsp_data_b   out  DATA_W  value of register cmd_b
//  op_err       out  1       one-cycle pulse on acceptance of illegal op
//  rf_write     out  1       register-file write enable
//  rf_dr        out  ADDR_W  register-file write index
//  rf_wrData    out  DATA_W  register-file write data
//  rf_sr1       out  ADDR_W  register-file read index 1
//  rf_sr2       out  ADDR_W  register-file read index 2
//  rf_rdData1   in   DATA_W  register-file read data 1 (combinational)
//  rf_rdData2   in   DATA_W  register-file read data 2 (combinational)
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; cmd_ready=1; rsp_valid=0; op_err=0; rf_write=0.
//    All rf_* index/data outputs, rsp_data_a/b and the clear counter reset to 0.
//  - Handshake: command accepted on a clk edge with cmd_valid & cmd_ready.
//    The controller registers all cmd_* fields at acceptance.
//    cmd_ready=1 only in IDLE, so at most one command is in flight.
//  - FSM: IDLE, WRITE, READ, RESP, CLEAR.
//  - IDLE: on acceptance, go to WRITE (00), READ (01) or CLEAR (10).
//    op 11: stay in IDLE and pulse op_err for 1 cycle; no rf_write.
//  - WRITE (1 cycle): rf_write=1, rf_dr=captured a, rf_wrData=captured data -> IDLE.
//    Write commits at the end of this cycle; a new command is accepted no earlier than 2 cycles after the previous acceptance.
//  - READ (1 cycle): rf_sr1=a, rf_sr2=b; capture rf_rdData1/2 into rsp_data_a/b at the end of the cycle -> RESP.
//  - RESP: rsp_valid=1 and rsp_data_a/b held stable until rsp_ready.
//    On rsp_valid & rsp_ready: rsp_valid=0 next cycle -> IDLE.
//    Read latency: rsp_valid asserts 2 cycles after acceptance.
//  - Identical read indices (a==b) are legal; both results are equal.
//  - CLEAR: NREGS consecutive cycles with rf_write=1, rf_dr=counter 0..NREGS-1, rf_wrData=0.
//    After the last index -> IDLE; the counter returns to 0 and does not wrap past NREGS-1.
//  - rf_write is 0 in every state except WRITE and CLEAR.
//  - Reset mid-operation aborts immediately: a partial CLEAR leaves the register contents unspecified, and any pending response is dropped.
// CONFIGURATION
//  Macro CTRL_BANCO_VERIFY_EN:
//  - Defined: WRITE is followed by a 1-cycle VERIFY state.
//    VERIFY drives rf_sr1=dr with rf_write=0 and compares rf_rdData1 to the written data.
//    A mismatch sets output wr_mismatch (1 bit, sticky); only reset clears it.
//    Write occupancy becomes 2 cycles.
//  - Undefined: no VERIFY state and no wr_mismatch port; WRITE returns directly to IDLE.
// TESTING
//  1. Release reset; WRITE a=2 data=8'hA5 -> rf_write=1 for exactly 1 cycle with rf_dr=2, rf_wrData=A5; cmd_ready back to 1 next cycle.
//  2. With reg2=A5 and reg1=3C: READ a=2 b=1 -> rsp_valid 2 cycles after acceptance with rsp_data_a=A5, rsp_data_b=3C.
//     Holding rsp_ready=0 for 5 cycles keeps valid and data stable; cmd_ready stays 0.
//  3. CLEAR after loading all regs with FF -> 4 consecutive writes dr=0,1,2,3, data 0; a subsequent READ 0/3 returns 00/00.
//  4. cmd_op=11 -> op_err pulses 1 cycle, no rf_write, cmd_ready stays 1; a back-to-back valid WRITE is accepted next cycle.
//  5. Assert reset during the CLEAR cycle at dr=1 -> all outputs immediately at reset values; after release a READ completes normally.
//  6. (VERIFY_EN) Force rf_rdData1 != data during VERIFY -> wr_mismatch=1, and it stays set after further good writes until reset.

Source files
------------

// File: rtl/controlador_banco.sv
// -----------------------------------------------------------------------------
// controlador_banco
//   Initiator-side controller for a small register-file port (one write port
//   dr/wrData, two combinational read ports sr1/sr2).  Commands arrive over a
//   valid/ready channel and are sequenced onto the register-file port.  Read
//   results return over a valid/ready response channel.
//
//   Commands (cmd_op): 00 WRITE, 01 READ pair, 10 CLEAR, 11 illegal.
//
//   Optional feature macro: CTRL_BANCO_VERIFY_EN
//     When defined, every WRITE is followed by a one-cycle VERIFY read-back of
//     the written register.  A mismatch sets the sticky output wr_mismatch,
//     which only reset clears.  When undefined, the port does not exist.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op/a/b/data       command fields, captured on acceptance
//   rsp_valid/rsp_ready   read response handshake
//   rsp_data_a/b          read results, stable while rsp_valid is high
//   op_err                one-cycle pulse when an illegal op is accepted
//   wr_mismatch           sticky write read-back error (VERIFY build only)
//   rf_write/dr/wrData    register-file write port
//   rf_sr1/sr2            register-file read indices
//   rf_rdData1/2          register-file read data (combinational)
// -----------------------------------------------------------------------------
module controlador_banco #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2,
   parameter int NREGS  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_a,
   input  logic [ADDR_W-1:0] cmd_b,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data_a,
   output logic [DATA_W-1:0] rsp_data_b,
   output logic              op_err,
`ifdef CTRL_BANCO_VERIFY_EN
   output logic              wr_mismatch,
`endif
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_dr,
   output logic [DATA_W-1:0] rf_wrData,
   output logic [ADDR_W-1:0] rf_sr1,
   output logic [ADDR_W-1:0] rf_sr2,
   input  logic [DATA_W-1:0] rf_rdData1,
   input  logic [DATA_W-1:0] rf_rdData2
);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;

   // Last index visited by CLEAR; the counter never advances past it.
   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NREGS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_READ   = 3'd2,
      ST_RESP   = 3'd3,
      ST_CLEAR  = 3'd4
`ifdef CTRL_BANCO_VERIFY_EN
      ,
      ST_VERIFY = 3'd5
`endif
   } state_t;

   state_t              state_q,      state_d;
   logic                cmd_ready_q,  cmd_ready_d;
   logic                rsp_valid_q,  rsp_valid_d;
   logic                op_err_q,     op_err_d;
   logic                rf_write_q,   rf_write_d;
   logic [ADDR_W-1:0]   rf_dr_q,      rf_dr_d;
   logic [DATA_W-1:0]   rf_wrdata_q,  rf_wrdata_d;
   logic [ADDR_W-1:0]   rf_sr1_q,     rf_sr1_d;
   logic [ADDR_W-1:0]   rf_sr2_q,     rf_sr2_d;
   logic [DATA_W-1:0]   rsp_data_a_q, rsp_data_a_d;
   logic [DATA_W-1:0]   rsp_data_b_q, rsp_data_b_d;
   logic [ADDR_W-1:0]   clr_cnt_q,    clr_cnt_d;
`ifdef CTRL_BANCO_VERIFY_EN
   logic                wr_mismatch_q, wr_mismatch_d;
`endif

   // Next-state and next-output computation; every output is registered so
   // values below describe what the port shows during the next state.
   always_comb begin
      state_d      = state_q;
      op_err_d     = 1'b0;
      rf_write_d   = 1'b0;
      rf_dr_d      = rf_dr_q;
      rf_wrdata_d  = rf_wrdata_q;
      rf_sr1_d     = rf_sr1_q;
      rf_sr2_d     = rf_sr2_q;
      rsp_data_a_d = rsp_data_a_q;
      rsp_data_b_d = rsp_data_b_q;
      clr_cnt_d    = clr_cnt_q;
`ifdef CTRL_BANCO_VERIFY_EN
      wr_mismatch_d = wr_mismatch_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               // Command fields are captured straight into the port registers.
               case (cmd_op)
                  OP_WRITE: begin
                     state_d     = ST_WRITE;
                     rf_write_d  = 1'b1;
                     rf_dr_d     = cmd_a;
                     rf_wrdata_d = cmd_data;
                  end
                  OP_READ: begin
                     state_d  = ST_READ;
                     rf_sr1_d = cmd_a;
                     rf_sr2_d = cmd_b;
                  end
                  OP_CLEAR: begin
                     state_d     = ST_CLEAR;
                     rf_write_d  = 1'b1;
                     clr_cnt_d   = {ADDR_W{1'b0}};
                     rf_dr_d     = {ADDR_W{1'b0}};
                     rf_wrdata_d = {DATA_W{1'b0}};
                  end
                  default: begin
                     // Illegal op: consumed, flagged, nothing touches the file.
                     state_d  = ST_IDLE;
                     op_err_d = 1'b1;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
`ifdef CTRL_BANCO_VERIFY_EN
            // Point read port 1 at the register just written.
            state_d  = ST_VERIFY;
            rf_sr1_d = rf_dr_q;
`else
            state_d  = ST_IDLE;
`endif
         end
`ifdef CTRL_BANCO_VERIFY_EN
         ST_VERIFY: begin
            state_d = ST_IDLE;
            if (rf_rdData1 != rf_wrdata_q) begin
               wr_mismatch_d = 1'b1;
            end else begin
               wr_mismatch_d = wr_mismatch_q;
            end
         end
`endif
         ST_READ: begin
            state_d      = ST_RESP;
            rsp_data_a_d = rf_rdData1;
            rsp_data_b_d = rf_rdData2;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_CLEAR: begin
            if (clr_cnt_q == CLR_LAST) begin
               state_d   = ST_IDLE;
               clr_cnt_d = {ADDR_W{1'b0}};
            end else begin
               state_d     = ST_CLEAR;
               clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
               rf_write_d  = 1'b1;
               rf_dr_d     = clr_cnt_q + ADDR_W'(1);
               rf_wrdata_d = {DATA_W{1'b0}};
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Handshake flags follow the state being entered.
      cmd_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         cmd_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         op_err_q      <= 1'b0;
         rf_write_q    <= 1'b0;
         rf_dr_q       <= {ADDR_W{1'b0}};
         rf_wrdata_q   <= {DATA_W{1'b0}};
         rf_sr1_q      <= {ADDR_W{1'b0}};
         rf_sr2_q      <= {ADDR_W{1'b0}};
         rsp_data_a_q  <= {DATA_W{1'b0}};
         rsp_data_b_q  <= {DATA_W{1'b0}};
         clr_cnt_q     <= {ADDR_W{1'b0}};
`ifdef CTRL_BANCO_VERIFY_EN
         wr_mismatch_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         op_err_q      <= op_err_d;
         rf_write_q    <= rf_write_d;
         rf_dr_q       <= rf_dr_d;
         rf_wrdata_q   <= rf_wrdata_d;
         rf_sr1_q      <= rf_sr1_d;
         rf_sr2_q      <= rf_sr2_d;
         rsp_data_a_q  <= rsp_data_a_d;
         rsp_data_b_q  <= rsp_data_b_d;
         clr_cnt_q     <= clr_cnt_d;
`ifdef CTRL_BANCO_VERIFY_EN
         wr_mismatch_q <= wr_mismatch_d;
`endif
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign op_err     = op_err_q;
   assign rf_write   = rf_write_q;
   assign rf_dr      = rf_dr_q;
   assign rf_wrData  = rf_wrdata_q;
   assign rf_sr1     = rf_sr1_q;
   assign rf_sr2     = rf_sr2_q;
   assign rsp_data_a = rsp_data_a_q;
   assign rsp_data_b = rsp_data_b_q;
`ifdef CTRL_BANCO_VERIFY_EN
   assign wr_mismatch = wr_mismatch_q;
`endif

endmodule

// File: tb/tb_controlador_banco.sv
// -----------------------------------------------------------------------------
// tb_controlador_banco
//   Self-checking bench for controlador_banco.  A behavioural 4x8 register file
//   sits on the rf_* port.  A table of commands with expected results is
//   replayed; read expectations go through a scoreboard queue and are popped
//   when the response appears.  Hand-written sequences cover response
//   back-pressure, CLEAR, illegal op followed by a back-to-back write, reset in
//   the middle of CLEAR and (VERIFY build) the sticky write mismatch flag.
// -----------------------------------------------------------------------------
module tb_controlador_banco;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [1:0] cmd_a = 2'd0;
   logic [1:0] cmd_b = 2'd0;
   logic [7:0] cmd_data = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data_a;
   logic [7:0] rsp_data_b;
   logic       op_err;
`ifdef CTRL_BANCO_VERIFY_EN
   logic       wr_mismatch;
`endif
   logic       rf_write;
   logic [1:0] rf_dr;
   logic [7:0] rf_wrData;
   logic [1:0] rf_sr1;
   logic [1:0] rf_sr2;
   logic [7:0] rf_rdData1;
   logic [7:0] rf_rdData2;

   int checks = 0;
   int errors = 0;

   // Register-file model; corrupt flips read port 1 to provoke a bad read-back.
   logic [7:0] rf_mem [0:3];
   logic       corrupt = 1'b0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (rf_write) rf_mem[rf_dr] <= rf_wrData;
   end

   assign rf_rdData1 = rf_mem[rf_sr1] ^ (corrupt ? 8'hFF : 8'h00);
   assign rf_rdData2 = rf_mem[rf_sr2];

   controlador_banco #(.DATA_W(8), .ADDR_W(2), .NREGS(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data_a (rsp_data_a),
      .rsp_data_b (rsp_data_b),
      .op_err     (op_err),
`ifdef CTRL_BANCO_VERIFY_EN
      .wr_mismatch(wr_mismatch),
`endif
      .rf_write   (rf_write),
      .rf_dr      (rf_dr),
      .rf_wrData  (rf_wrData),
      .rf_sr1     (rf_sr1),
      .rf_sr2     (rf_sr2),
      .rf_rdData1 (rf_rdData1),
      .rf_rdData2 (rf_rdData2)
   );

   typedef struct {
      logic [1:0] op;
      logic [1:0] a;
      logic [1:0] b;
      logic [7:0] data;
      logic [7:0] exp_a;
      logic [7:0] exp_b;
   } vec_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
   } rsp_t;

   rsp_t sbq[$];
   vec_t vecs[10];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Waits (bounded) at falling edges for cmd_ready.
   task automatic wait_ready();
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_wait", 8'(cmd_ready), 8'h01);
   endtask

   // Presents one command, returns #1 after the accepting edge with valid low.
   task automatic issue(input logic [1:0] op, input logic [1:0] a,
                        input logic [1:0] b, input logic [7:0] d);
      @(negedge clk);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_data  = d;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic pop_compare();
      rsp_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL sb_empty actual=response expected=none at %0t", $time);
      end else begin
         e = sbq.pop_front();
         chk("rsp_data_a", rsp_data_a, e.a);
         chk("rsp_data_b", rsp_data_b, e.b);
      end
   endtask

   // Finishes a write already accepted: checks the one write pulse.
   task automatic finish_write(input logic [1:0] a, input logic [7:0] d);
      chk("wr_en", 8'(rf_write), 8'h01);
      chk("wr_dr", 8'(rf_dr), 8'(a));
      chk("wr_data", rf_wrData, d);
      chk("wr_busy", 8'(cmd_ready), 8'h00);
      @(posedge clk); #1;
      chk("wr_en_off", 8'(rf_write), 8'h00);
`ifdef CTRL_BANCO_VERIFY_EN
      chk("verify_busy", 8'(cmd_ready), 8'h00);
      chk("verify_sr1", 8'(rf_sr1), 8'(a));
      @(posedge clk); #1;
`endif
      chk("wr_ready_back", 8'(cmd_ready), 8'h01);
   endtask

   task automatic run_vec(input vec_t v);
      rsp_t r;
      if (v.op == 2'b01) begin
         r.a = v.exp_a;
         r.b = v.exp_b;
         sbq.push_back(r);
      end
      issue(v.op, v.a, v.b, v.data);
      case (v.op)
         2'b00: finish_write(v.a, v.data);
         2'b01: begin
            chk("rd_lat1_valid", 8'(rsp_valid), 8'h00);
            chk("rd_busy", 8'(cmd_ready), 8'h00);
            @(posedge clk); #1;
            chk("rd_lat2_valid", 8'(rsp_valid), 8'h01);
            pop_compare();
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            chk("rsp_drop", 8'(rsp_valid), 8'h00);
            chk("rd_ready_back", 8'(cmd_ready), 8'h01);
         end
         2'b11: begin
            chk("ill_err", 8'(op_err), 8'h01);
            chk("ill_nowr", 8'(rf_write), 8'h00);
            chk("ill_ready", 8'(cmd_ready), 8'h01);
            @(posedge clk); #1;
            chk("ill_err_off", 8'(op_err), 8'h00);
         end
         default: chk("vec_op", 8'(v.op), 8'h00);
      endcase
   endtask

   task automatic chk_reset_vals();
      chk("rst_ready", 8'(cmd_ready), 8'h01);
      chk("rst_rsp_valid", 8'(rsp_valid), 8'h00);
      chk("rst_op_err", 8'(op_err), 8'h00);
      chk("rst_write", 8'(rf_write), 8'h00);
      chk("rst_dr", 8'(rf_dr), 8'h00);
      chk("rst_wrdata", rf_wrData, 8'h00);
      chk("rst_sr1", 8'(rf_sr1), 8'h00);
      chk("rst_sr2", 8'(rf_sr2), 8'h00);
      chk("rst_rsp_a", rsp_data_a, 8'h00);
      chk("rst_rsp_b", rsp_data_b, 8'h00);
   endtask

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      vecs[0] = '{2'b00, 2'd0, 2'd0, 8'h11, 8'h00, 8'h00};
      vecs[1] = '{2'b00, 2'd1, 2'd0, 8'h3C, 8'h00, 8'h00};
      vecs[2] = '{2'b00, 2'd2, 2'd0, 8'hA5, 8'h00, 8'h00};
      vecs[3] = '{2'b00, 2'd3, 2'd0, 8'h7E, 8'h00, 8'h00};
      vecs[4] = '{2'b01, 2'd2, 2'd1, 8'h00, 8'hA5, 8'h3C};
      vecs[5] = '{2'b01, 2'd0, 2'd3, 8'h00, 8'h11, 8'h7E};
      vecs[6] = '{2'b01, 2'd3, 2'd3, 8'h00, 8'h7E, 8'h7E};
      vecs[7] = '{2'b11, 2'd1, 2'd2, 8'h99, 8'h00, 8'h00};
      vecs[8] = '{2'b00, 2'd1, 2'd0, 8'hC3, 8'h00, 8'h00};
      vecs[9] = '{2'b01, 2'd1, 2'd0, 8'h00, 8'hC3, 8'h11};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals();
      @(negedge clk);
      reset = 1'b1;

      // Table-driven commands.
      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Response back-pressure: reg2=A5, reg1=3C.
      v = '{2'b00, 2'd1, 2'd0, 8'h3C, 8'h00, 8'h00};
      run_vec(v);
      sbq.push_back('{8'hA5, 8'h3C});
      issue(2'b01, 2'd2, 2'd1, 8'h00);
      @(posedge clk); #1;
      chk("bp_valid", 8'(rsp_valid), 8'h01);
      pop_compare();
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", 8'(rsp_valid), 8'h01);
         chk("bp_hold_a", rsp_data_a, 8'hA5);
         chk("bp_hold_b", rsp_data_b, 8'h3C);
         chk("bp_busy", 8'(cmd_ready), 8'h00);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp_drop", 8'(rsp_valid), 8'h00);
      chk("bp_ready_back", 8'(cmd_ready), 8'h01);

      // CLEAR after filling with FF.
      for (int r = 0; r < 4; r++) begin
         v = '{2'b00, 2'(r), 2'd0, 8'hFF, 8'h00, 8'h00};
         run_vec(v);
      end
      issue(2'b10, 2'd0, 2'd0, 8'h00);
      for (int r = 0; r < 4; r++) begin
         chk("clr_wr", 8'(rf_write), 8'h01);
         chk("clr_dr", 8'(rf_dr), 8'(r));
         chk("clr_data", rf_wrData, 8'h00);
         chk("clr_busy", 8'(cmd_ready), 8'h00);
         @(posedge clk); #1;
      end
      chk("clr_done_wr", 8'(rf_write), 8'h00);
      chk("clr_done_ready", 8'(cmd_ready), 8'h01);
      v = '{2'b01, 2'd0, 2'd3, 8'h00, 8'h00, 8'h00};
      run_vec(v);

      // Illegal op with a back-to-back WRITE held on the bus.
      @(negedge clk);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      @(posedge clk); #1;
      chk("b2b_err", 8'(op_err), 8'h01);
      chk("b2b_nowr", 8'(rf_write), 8'h00);
      chk("b2b_ready", 8'(cmd_ready), 8'h01);
      cmd_op   = 2'b00;
      cmd_a    = 2'd0;
      cmd_data = 8'h66;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("b2b_err_off", 8'(op_err), 8'h00);
      finish_write(2'd0, 8'h66);

      // Reset while CLEAR is at index 1.
      issue(2'b10, 2'd0, 2'd0, 8'h00);
      chk("mid_dr0", 8'(rf_dr), 8'h00);
      @(posedge clk); #1;
      chk("mid_dr1", 8'(rf_dr), 8'h01);
      chk("mid_wr1", 8'(rf_write), 8'h01);
      reset = 1'b0;
      #1;
      chk_reset_vals();
      @(negedge clk);
      reset = 1'b1;
      v = '{2'b00, 2'd3, 2'd0, 8'h5A, 8'h00, 8'h00};
      run_vec(v);
      v = '{2'b01, 2'd3, 2'd3, 8'h00, 8'h5A, 8'h5A};
      run_vec(v);

`ifdef CTRL_BANCO_VERIFY_EN
      // Sticky read-back mismatch.
      chk("mm_clean", 8'(wr_mismatch), 8'h00);
      corrupt = 1'b1;
      v = '{2'b00, 2'd2, 2'd0, 8'h42, 8'h00, 8'h00};
      run_vec(v);
      corrupt = 1'b0;
      chk("mm_set", 8'(wr_mismatch), 8'h01);
      v = '{2'b00, 2'd1, 2'd0, 8'h24, 8'h00, 8'h00};
      run_vec(v);
      chk("mm_sticky", 8'(wr_mismatch), 8'h01);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mm_reset", 8'(wr_mismatch), 8'h00);
      @(negedge clk);
      reset = 1'b1;
`endif

      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover actual=%0d expected=0", sbq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
